mem_stage: RTL and testbench

- Memory-access stage of the 16-bit pipelined CPU.
- Sits between the EX/MEM boundary and the write-back stage.
- Issues loads and stores to data memory over a request/ready handshake, and stalls the upstream pipeline while memory is busy.
- Owns the MEM/WB pipeline register that feeds write-back: rf_write, memtoreg, dm_data, result, rf_write_reg.

---
 rtl/mem_stage.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the 16-bit pipelined CPU.
//
// Takes the instruction held in the EX/MEM register, issues loads and stores
// to data memory over a req/ready handshake, stalls upstream while memory is
// busy, and owns the MEM/WB register that feeds write-back.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   valid_in, flush   live-instruction qualifier and kill (IDLE only)
//   rf_write_in, memtoreg_in, memread_in, memwrite_in   control bits
//   result_in         ALU result / memory address
//   store_data_in     store data
//   rf_write_reg_in   destination register
//   stall             upstream must hold its inputs (combinational)
//   dm_req, dm_we, dm_addr, dm_wdata, dm_rdata, dm_ready   data-memory port
//   rf_write, memtoreg, dm_data, result, rf_write_reg       MEM/WB register
//   err               sticky memory-timeout flag

module mem_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              flush,
  input  logic              rf_write_in,
  input  logic              memtoreg_in,
  input  logic              memread_in,
  input  logic              memwrite_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic [REG_AW-1:0] rf_write_reg_in,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ready,
  output logic              rf_write,
  output logic              memtoreg,
  output logic [DATA_W-1:0] dm_data,
  output logic [DATA_W-1:0] result,
  output logic [REG_AW-1:0] rf_write_reg,
  output logic              err
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;

  // Copy of the in-flight memory instruction, so WAIT is independent of upstream.
  logic [DATA_W-1:0]   lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
  logic                lat_we_q, lat_we_d;
  logic                lat_rfw_q, lat_rfw_d;
  logic                lat_m2r_q, lat_m2r_d;
  logic [REG_AW-1:0]   lat_dest_q, lat_dest_d;

  // MEM/WB register.
  logic                rf_write_q, rf_write_d;
  logic                memtoreg_q, memtoreg_d;
  logic [DATA_W-1:0]   dm_data_q, dm_data_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [REG_AW-1:0]   dest_q, dest_d;
  logic                err_q, err_d;

  logic                live_s, memop_s;
  logic                stall_s, req_s, we_s;
  logic [DATA_W-1:0]   addr_s, wdata_s;

  assign live_s  = valid_in & ~flush;
  assign memop_s = memread_in | memwrite_in;

  // Next-state, MEM/WB capture and memory-port drive.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_we_d    = lat_we_q;
    lat_rfw_d   = lat_rfw_q;
    lat_m2r_d   = lat_m2r_q;
    lat_dest_d  = lat_dest_q;
    rf_write_d  = rf_write_q;
    memtoreg_d  = memtoreg_q;
    dm_data_d   = dm_data_q;
    result_d    = result_q;
    dest_d      = dest_q;
    err_d       = err_q;
    stall_s     = 1'b0;
    req_s       = 1'b0;
    we_s        = lat_we_q;
    addr_s      = lat_addr_q;
    wdata_s     = lat_wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (live_s && memop_s) begin
          // A set memwrite_in wins over memread_in: both set means store.
          req_s       = 1'b1;
          we_s        = memwrite_in;
          addr_s      = result_in;
          wdata_s     = store_data_in;
          lat_addr_d  = result_in;
          lat_wdata_d = store_data_in;
          lat_we_d    = memwrite_in;
          lat_rfw_d   = rf_write_in;
          lat_m2r_d   = memtoreg_in;
          lat_dest_d  = rf_write_reg_in;
          if (dm_ready) begin
            rf_write_d = rf_write_in & ~memwrite_in;
            memtoreg_d = memtoreg_in;
            dm_data_d  = memwrite_in ? {DATA_W{1'b0}} : dm_rdata;
            result_d   = result_in;
            dest_d     = rf_write_reg_in;
          end else begin
            stall_s    = 1'b1;
            rf_write_d = 1'b0;
            state_d    = ST_WAIT;
            cnt_d      = 8'd1;
          end
        end else if (live_s) begin
          rf_write_d = rf_write_in;
          memtoreg_d = memtoreg_in;
          dm_data_d  = {DATA_W{1'b0}};
          result_d   = result_in;
          dest_d     = rf_write_reg_in;
        end else begin
          rf_write_d = 1'b0;
        end
      end

      ST_WAIT: begin
        req_s   = 1'b1;
        stall_s = 1'b1;
        if (dm_ready) begin
          // Release upstream this cycle so it advances on the completing edge.
          stall_s    = 1'b0;
          rf_write_d = lat_rfw_q & ~lat_we_q;
          memtoreg_d = lat_m2r_q;
          dm_data_d  = lat_we_q ? {DATA_W{1'b0}} : dm_rdata;
          result_d   = lat_addr_q;
          dest_d     = lat_dest_q;
          state_d    = ST_IDLE;
          cnt_d      = 8'd0;
        end else if (cnt_q == TIMEOUT_C) begin
          // Abort: retire the instruction without a register write.
          stall_s    = 1'b0;
          rf_write_d = 1'b0;
          memtoreg_d = lat_m2r_q;
          dm_data_d  = {DATA_W{1'b0}};
          result_d   = lat_addr_q;
          dest_d     = lat_dest_q;
          err_d      = 1'b1;
          state_d    = ST_IDLE;
          cnt_d      = 8'd0;
        end else begin
          rf_write_d = 1'b0;
          cnt_d      = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d    = ST_IDLE;
        cnt_d      = 8'd0;
        rf_write_d = 1'b0;
      end
    endcase
  end

  // State, latched request and MEM/WB register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      lat_addr_q  <= {DATA_W{1'b0}};
      lat_wdata_q <= {DATA_W{1'b0}};
      lat_we_q    <= 1'b0;
      lat_rfw_q   <= 1'b0;
      lat_m2r_q   <= 1'b0;
      lat_dest_q  <= {REG_AW{1'b0}};
      rf_write_q  <= 1'b0;
      memtoreg_q  <= 1'b0;
      dm_data_q   <= {DATA_W{1'b0}};
      result_q    <= {DATA_W{1'b0}};
      dest_q      <= {REG_AW{1'b0}};
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_we_q    <= lat_we_d;
      lat_rfw_q   <= lat_rfw_d;
      lat_m2r_q   <= lat_m2r_d;
      lat_dest_q  <= lat_dest_d;
      rf_write_q  <= rf_write_d;
      memtoreg_q  <= memtoreg_d;
      dm_data_q   <= dm_data_d;
      result_q    <= result_d;
      dest_q      <= dest_d;
      err_q       <= err_d;
    end
  end

  // Reset gates the handshake outputs even if upstream presents a memory op.
  assign stall        = stall_s & ~rst;
  assign dm_req       = req_s & ~rst;
  assign dm_we        = we_s;
  assign dm_addr      = addr_s;
  assign dm_wdata     = wdata_s;

  assign rf_write     = rf_write_q;
  assign memtoreg     = memtoreg_q;
  assign dm_data      = dm_data_q;
  assign result       = result_q;
  assign rf_write_reg = dest_q;
  assign err          = err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random
// instructions, checked against a transaction-level model of the stage.

module tb_mem_stage;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in, flush, rf_write_in, memtoreg_in, memread_in, memwrite_in;
  logic [DW-1:0] result_in, store_data_in, dm_rdata;
  logic [AW-1:0] rf_write_reg_in;
  logic          dm_ready;
  logic          stall, dm_req, dm_we;
  logic [DW-1:0] dm_addr, dm_wdata, dm_data, result;
  logic          rf_write, memtoreg, err;
  logic [AW-1:0] rf_write_reg;

  int n_checks = 0;
  int n_errors = 0;

  // Expected MEM/WB contents.
  logic          e_rfw, e_m2r, e_err;
  logic [DW-1:0] e_dmd, e_res;
  logic [AW-1:0] e_dst;

  mem_stage #(.DATA_W(DW), .REG_AW(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush),
    .rf_write_in(rf_write_in), .memtoreg_in(memtoreg_in),
    .memread_in(memread_in), .memwrite_in(memwrite_in),
    .result_in(result_in), .store_data_in(store_data_in),
    .rf_write_reg_in(rf_write_reg_in), .stall(stall), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .rf_write(rf_write),
    .memtoreg(memtoreg), .dm_data(dm_data), .result(result),
    .rf_write_reg(rf_write_reg), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_regs(input string tag);
    check_val({tag, ".rf_write"}, 32'(rf_write), 32'(e_rfw));
    check_val({tag, ".memtoreg"}, 32'(memtoreg), 32'(e_m2r));
    check_val({tag, ".dm_data"}, 32'(dm_data), 32'(e_dmd));
    check_val({tag, ".result"}, 32'(result), 32'(e_res));
    check_val({tag, ".rf_write_reg"}, 32'(rf_write_reg), 32'(e_dst));
    check_val({tag, ".err"}, 32'(err), 32'(e_err));
  endtask

  task automatic model_reset();
    e_rfw = 1'b0; e_m2r = 1'b0; e_err = 1'b0;
    e_dmd = '0; e_res = '0; e_dst = '0;
  endtask

  task automatic randomize_upstream();
    valid_in        = 1'($urandom);
    flush           = 1'($urandom);
    rf_write_in     = 1'($urandom);
    memtoreg_in     = 1'($urandom);
    memread_in      = 1'($urandom);
    memwrite_in     = 1'($urandom);
    result_in       = 16'($urandom);
    store_data_in   = 16'($urandom);
    rf_write_reg_in = 4'($urandom);
  endtask

  // kind: 0 no valid, 1 ALU, 2 load, 3 store, 4 read+write (a store).
  // lat: request-cycle index on which memory answers; beyond TMO it times out.
  task automatic do_instr(input string tag, input int kind, input bit fl, input int lat,
                          input logic [DW-1:0] a, input logic [DW-1:0] wd,
                          input logic [DW-1:0] rd, input logic rfw, input logic m2r,
                          input logic [AW-1:0] dst);
    bit live, mem, st, ok;
    int n;
    live = (kind != 0) && !fl;
    mem  = live && (kind >= 2);
    st   = (kind >= 3);
    ok   = (lat <= TMO);
    n    = mem ? (ok ? lat : TMO) : 0;
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i == 0) begin
        randomize_upstream();
        valid_in        = (kind != 0);
        flush           = fl;
        rf_write_in     = rfw;
        memtoreg_in     = m2r;
        result_in       = a;
        store_data_in   = wd;
        rf_write_reg_in = dst;
        if (kind != 0) begin
          memread_in  = (kind == 2) || (kind == 4);
          memwrite_in = (kind >= 3);
        end
      end else begin
        randomize_upstream();
      end
      dm_ready = mem && (i == lat);
      dm_rdata = dm_ready ? rd : 16'($urandom);
      #1;
      check_val({tag, ".stall"}, 32'(stall), 32'(mem && (i < n)));
      check_val({tag, ".dm_req"}, 32'(dm_req), 32'(mem));
      if (mem) begin
        check_val({tag, ".dm_addr"}, 32'(dm_addr), 32'(a));
        check_val({tag, ".dm_we"}, 32'(dm_we), 32'(st));
        if (st) begin
          check_val({tag, ".dm_wdata"}, 32'(dm_wdata), 32'(wd));
        end
      end
      @(posedge clk);
      #1;
      if (i < n) begin
        e_rfw = 1'b0;
      end else if (!live) begin
        e_rfw = 1'b0;
      end else if (!mem) begin
        e_rfw = rfw; e_m2r = m2r; e_dmd = '0; e_res = a; e_dst = dst;
      end else if (ok) begin
        e_rfw = rfw && !st; e_m2r = m2r; e_dmd = st ? 16'h0000 : rd;
        e_res = a; e_dst = dst;
      end else begin
        e_rfw = 1'b0; e_m2r = m2r; e_dmd = '0; e_res = a; e_dst = dst; e_err = 1'b1;
      end
      check_regs(tag);
    end
  endtask

  initial begin
    rst = 1'b1;
    randomize_upstream();
    valid_in = 1'b1; flush = 1'b0; memread_in = 1'b1; memwrite_in = 1'b0;
    dm_ready = 1'b0; dm_rdata = 16'h0000;
    model_reset();
    #12;
    check_val("reset.dm_req", 32'(dm_req), 32'd0);
    check_val("reset.stall", 32'(stall), 32'd0);
    check_regs("reset");
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b0;

    do_instr("alu", 1, 1'b0, 0, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'h5);
    do_instr("load0", 2, 1'b0, 0, 16'h0040, 16'h0000, 16'hBEEF, 1'b1, 1'b1, 4'h3);
    do_instr("load3", 2, 1'b0, 2, 16'h0088, 16'h0000, 16'hCAFE, 1'b1, 1'b1, 4'h7);
    do_instr("st_flush", 3, 1'b1, 0, 16'h0010, 16'h00FF, 16'h0000, 1'b1, 1'b0, 4'h2);
    do_instr("store", 3, 1'b0, 0, 16'h0010, 16'h00FF, 16'h1111, 1'b1, 1'b0, 4'h2);
    do_instr("idle", 0, 1'b0, 0, 16'h5555, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'h9);
    do_instr("timeout", 2, 1'b0, 10, 16'h0200, 16'h0000, 16'h2222, 1'b1, 1'b1, 4'hA);
    do_instr("after_to", 1, 1'b0, 0, 16'h0ABC, 16'h0000, 16'h0000, 1'b1, 1'b0, 4'h4);

    // Reset while a load is waiting: everything returns to zero at once.
    @(negedge clk);
    valid_in = 1'b1; flush = 1'b0; memread_in = 1'b1; memwrite_in = 1'b0;
    result_in = 16'h0300; dm_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check_val("rst_wait.pre_stall", 32'(stall), 32'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check_val("rst_wait.dm_req", 32'(dm_req), 32'd0);
    check_val("rst_wait.stall", 32'(stall), 32'd0);
    check_regs("rst_wait");
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b0;
    do_instr("post_rst", 1, 1'b0, 0, 16'h7777, 16'h0000, 16'h0000, 1'b1, 1'b1, 4'h1);

    for (int k = 0; k < 300; k++) begin
      do_instr("rand", int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0),
               int'($urandom_range(0, 6)), 16'($urandom), 16'($urandom), 16'($urandom),
               1'($urandom), 1'($urandom), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
